// File: rtl/visor_ocupacion_pkg.sv
// Shared types and 7-segment encodings for the occupancy display stage.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package visor_ocupacion_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/visor_ocupacion_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, bcd only changes with a
// complete result so the display never sees a partial conversion.
module bin2bcd_seq
  import visor_ocupacion_pkg::*;
#(
  parameter int BIN_W  = 3,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);

  conv_state_t      state;
  logic [BIN_W-1:0] sh;
  logic [BW-1:0]    scratch, adj, nxt;
  logic [CW-1:0]    bit_cnt;

  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++)
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    nxt = {adj[BW-2:0], sh[BIN_W-1]};
  end

  // The result is committed on the last shift edge, giving BIN_W+2 cycles
  // from a count change to an updated bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sh      <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sh    <= bin;
          state <= S_LOAD;
        end
        S_LOAD: begin
          scratch <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          scratch <= nxt;
          sh      <= sh << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(BIN_W-1)) begin
            bcd   <= nxt;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: rtl/visor_ocupacion.sv
// Occupancy display: BCD conversion, multiplexed 7-segment scan, full-state
// blink, event dp flash and buzzer on entry attempts while full.
module visor_ocupacion
  import visor_ocupacion_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int COUNT_W    = 3,
  parameter int DIGITS     = 2,
  parameter int HOLD_TICKS = 200
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               full_in,
  input  logic               ev_in,
  input  logic               ev_out,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [DIGITS-1:0]  an,
  output logic               buzzer
);
  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2*BLINK_HZ);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HW  = $clog2(HOLD_TICKS+1);
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW  = 4*DIGITS;

  logic [SW-1:0]      scan_cnt;
  logic               scan_tick;
  logic [BLW-1:0]     blink_cnt;
  logic               blink_phase;
  logic [DW-1:0]      digit_idx;
  logic [HW-1:0]      hold_cnt, buz_cnt;
  logic [COUNT_W-1:0] last_cnt;
  logic               conv_valid, start, busy, done;
  logic [BW-1:0]      bcd;
  logic [DIGITS-1:0]  upper_zero;
  logic [3:0]         nib;
  logic               blank;

  assign start = !conv_valid || (count_in != last_cnt);

  bin2bcd_seq #(.BIN_W(COUNT_W), .DIGITS(DIGITS)) u_conv (
    .clk   (CLK),
    .rst_n (RST),
    .start (start),
    .bin   (count_in),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_cnt   <= '0;
      conv_valid <= 1'b0;
    end else begin
      if (start && !busy) last_cnt <= count_in;
      if (done)           conv_valid <= 1'b1;
    end
  end

  assign scan_tick = (scan_cnt == SW'(SCAN_DIV-1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick)
        digit_idx <= (digit_idx == DW'(DIGITS-1)) ? '0 : digit_idx + 1'b1;
    end
  end

  // Blink timebase only runs while full so the phase restarts cleanly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!full_in) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLW'(BLINK_DIV-1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt <= '0;
      buz_cnt  <= '0;
    end else begin
      if (ev_in || ev_out)                 hold_cnt <= HW'(HOLD_TICKS);
      else if (scan_tick && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (ev_in && full_in)                buz_cnt <= HW'(HOLD_TICKS);
      else if (scan_tick && buz_cnt != '0)  buz_cnt <= buz_cnt - 1'b1;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign upper_zero[k] = (bcd[BW-1:4*k] == '0);
  end

  assign nib   = bcd[{digit_idx, 2'b00} +: 4];
  assign blank = (digit_idx != '0) && upper_zero[digit_idx];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= ((full_in && blink_phase) || blank) ? SEG_BLANK : seg_decode(nib);
      dp  <= !((digit_idx == '0) && (hold_cnt != '0));
    end
  end

  assign buzzer = (buz_cnt != '0);

endmodule

// File: tb/tb_visor_ocupacion.sv
// Randomised bench for visor_ocupacion against a timeline model built from
// edge counts since reset (scan slots, blink runs, expiry edges, conversion schedule).
module tb_visor_ocupacion;
  localparam int DIGITS = 2, COUNT_W = 3, HOLD = 3, SDIV = 10, BDIV = 10;

  logic               CLK = 1'b0, RST = 1'b0;
  logic [COUNT_W-1:0] count_in = '0;
  logic               full_in = 1'b0, ev_in = 1'b0, ev_out = 1'b0;
  logic [6:0]         seg;
  logic               dp;
  logic [DIGITS-1:0]  an;
  logic               buzzer;

  int n_chk = 0, n_fail = 0;

  visor_ocupacion #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(50), .COUNT_W(COUNT_W),
                    .DIGITS(DIGITS), .HOLD_TICKS(HOLD)) dut (
    .CLK(CLK), .RST(RST), .count_in(count_in), .full_in(full_in), .ev_in(ev_in),
    .ev_out(ev_out), .seg(seg), .dp(dp), .an(an), .buzzer(buzzer));

  always #5 CLK = ~CLK;

  int segtab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  // model state: n = posedges since reset release
  int n, run, bcd_val, last, pend_val, pend_at, free_at, hold_exp, buz_exp;
  bit valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; run = 0; bcd_val = 0; last = 0; valid = 0;
    pend_val = 0; pend_at = -1; free_at = 0; hold_exp = 0; buz_exp = 0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_seg", seg, 'h7F);
    chk("rst_an", an, 'h3);
    chk("rst_dp", dp, 1);
    chk("rst_buzzer", buzzer, 0);
  endtask

  task automatic step();
    int d, p, dig, e_seg, e_an, e_dp, e_bcd;
    bit ph;
    @(posedge CLK);
    n++;
    d   = ((n-1) / SDIV) % DIGITS;
    p   = (d == 0) ? 1 : 10;
    ph  = ((run / BDIV) % 2) == 1;
    dig = (bcd_val / p) % 10;
    if (full_in && ph)             e_seg = 'h7F;
    else if (d > 0 && bcd_val < p) e_seg = 'h7F;
    else                           e_seg = segtab[dig];
    e_an = ((1 << DIGITS) - 1) & ~(1 << d);
    e_dp = (d == 0 && (n-1) < hold_exp) ? 0 : 1;
    run = full_in ? run + 1 : 0;
    if (ev_in || ev_out)   hold_exp = (n / SDIV + HOLD) * SDIV;
    if (ev_in && full_in)  buz_exp  = (n / SDIV + HOLD) * SDIV;
    if (n == pend_at) bcd_val = pend_val;
    if (n >= free_at && (!valid || int'(count_in) != last)) begin
      last = int'(count_in); valid = 1; pend_val = last;
      pend_at = n + COUNT_W + 1; free_at = n + COUNT_W + 3;
    end
    e_bcd = (((bcd_val / 10) % 10) << 4) | (bcd_val % 10);
    @(negedge CLK);
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("dp", dp, e_dp);
    chk("buzzer", buzzer, (n < buz_exp) ? 1 : 0);
    chk("bcd", dut.u_conv.bcd, e_bcd);
  endtask

  initial begin
    model_reset();
    #22;
    chk_reset_outs();
    @(negedge CLK); RST = 1'b1; model_reset();

    // count 0: digit0 shows 0, digit1 blank, scan alternates
    repeat (45) step();

    // conversion latency, then a change during SHIFT
    count_in = 3'd7;
    repeat (5) step();
    chk("conv_lat", dut.u_conv.bcd, 'h07);
    count_in = 3'd0;
    repeat (10) step();
    count_in = 3'd7;
    repeat (3) step();
    count_in = 3'd5;
    repeat (12) step();
    chk("conv_settle", dut.u_conv.bcd, 'h05);

    // blink while full, steady after release
    count_in = 3'd7; full_in = 1'b1;
    repeat (45) step();
    full_in = 1'b0;
    repeat (5) step();

    // exit event: dp flash, no buzzer
    ev_out = 1'b1; step(); ev_out = 1'b0;
    repeat (40) step();

    // entry while full, retrigger at a later tick
    full_in = 1'b1;
    while ((n + 1) % SDIV != 0) step();
    ev_in = 1'b1; step(); ev_in = 1'b0;
    repeat (20) step();
    ev_in = 1'b1; step(); ev_in = 1'b0;
    repeat (40) step();
    full_in = 1'b0;

    // simultaneous entry/exit on a scan tick
    while ((n + 1) % SDIV != 0) step();
    ev_in = 1'b1; ev_out = 1'b1; step(); ev_in = 1'b0; ev_out = 1'b0;
    chk("hold_load", dut.hold_cnt, HOLD);
    repeat (35) step();

    // reset mid-operation with buzzer and dp active
    full_in = 1'b1; count_in = 3'd6;
    ev_in = 1'b1; step(); ev_in = 1'b0;
    repeat (4) step();
    #2 RST = 1'b0;
    #1 chk_reset_outs();
    @(negedge CLK);
    chk_reset_outs();
    @(negedge CLK); RST = 1'b1; model_reset();
    full_in = 1'b0;
    repeat (12) step();

    // randomised traffic
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0)  count_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) full_in = ~full_in;
      ev_in  = ($urandom_range(0, 29) == 0);
      ev_out = ($urandom_range(0, 29) == 0);
      step();
    end
    ev_in = 1'b0; ev_out = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
